// File: rtl/gol_cursor_ctrl_pkg.sv
// Shared types and helpers for the GOL edit-mode cursor controller.
//   zoom_t      : viewport zoom level (32, 16 or 8 cells wide)
//   tog_state_t : cell-toggle request handshake state
//   action_t    : single arbitrated action applied in a cycle
//   zoomStep()  : next zoom level in the 32 -> 16 -> 8 -> 32 cycle
//   zoomCells() : viewport width in cells for a zoom level
package gol_cursor_ctrl_pkg;

  typedef enum logic [1:0] {
    Z32 = 2'd0,
    Z16 = 2'd1,
    Z8  = 2'd2
  } zoom_t;

  localparam logic [7:0] NUMCELLS_Z32 = 8'd32;
  localparam logic [7:0] NUMCELLS_Z16 = 8'd16;
  localparam logic [7:0] NUMCELLS_Z8  = 8'd8;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } tog_state_t;

  typedef enum logic [2:0] {
    ACT_NONE  = 3'd0,
    ACT_RUN   = 3'd1,
    ACT_TOG   = 3'd2,
    ACT_ZOOM  = 3'd3,
    ACT_UP    = 3'd4,
    ACT_DOWN  = 3'd5,
    ACT_LEFT  = 3'd6,
    ACT_RIGHT = 3'd7
  } action_t;

  // Button indices into the conditioned event vector. Direction buttons
  // occupy the low indices so the auto-repeat instances form one range.
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_ZOOM  = 4;
  localparam int BTN_RUN   = 5;
  localparam int BTN_TOG   = 6;
  localparam int NUM_BTN   = 7;

  function automatic zoom_t zoomStep(input zoom_t z);
    case (z)
      Z32:     zoomStep = Z16;
      Z16:     zoomStep = Z8;
      default: zoomStep = Z32;
    endcase
  endfunction

  function automatic logic [7:0] zoomCells(input zoom_t z);
    case (z)
      Z16:     zoomCells = NUMCELLS_Z16;
      Z8:      zoomCells = NUMCELLS_Z8;
      default: zoomCells = NUMCELLS_Z32;
    endcase
  endfunction

endpackage

// File: rtl/gol_cursor_ctrl_btn_conditioner.sv
// Raw push-button conditioner: 2-flop synchroniser, rising-edge detector and
// optional hold-to-repeat.
//   clk   in  system clock
//   rst_b in  synchronous active-low reset
//   raw   in  asynchronous button level, active-high
//   evt   out one-cycle event: on the press edge and, when REPEAT_EN=1, after
//             HOLD_CYC cycles of holding and then every RPT_CYC cycles
module gol_cursor_ctrl_btn_conditioner #(
  parameter int HOLD_CYC  = 5000000,
  parameter int RPT_CYC   = 1250000,
  parameter bit REPEAT_EN = 1'b0
) (
  input  logic clk,
  input  logic rst_b,
  input  logic raw,
  output logic evt
);

  logic syncQ1Reg;
  logic syncQ2Reg;
  logic prevReg;
  logic rise;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      syncQ1Reg <= 1'b0;
      syncQ2Reg <= 1'b0;
      prevReg   <= 1'b0;
    end else begin
      syncQ1Reg <= raw;
      syncQ2Reg <= syncQ1Reg;
      prevReg   <= syncQ2Reg;
    end
  end

  // Combinational edge so the event lands in the cycle after the second
  // synchroniser stage goes high; state using it updates on the next edge.
  assign rise = syncQ2Reg & ~prevReg;

  generate
    if (REPEAT_EN) begin : gRepeat
      localparam int MAX_CYC = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
      localparam int CW      = $clog2(MAX_CYC + 1);

      logic [CW-1:0] cntReg;
      logic          repeatingReg;
      logic          rptFire;

      // cntReg counts cycles since the last event (1 in the cycle after it).
      // Qualifying with prevReg keeps a stale count from firing on the edge.
      always_comb begin
        rptFire = syncQ2Reg & prevReg &
                  (cntReg == (repeatingReg ? CW'(RPT_CYC) : CW'(HOLD_CYC)));
      end

      always_ff @(posedge clk) begin
        if (!rst_b) begin
          cntReg       <= '0;
          repeatingReg <= 1'b0;
        end else if (!syncQ2Reg) begin
          cntReg       <= '0;
          repeatingReg <= 1'b0;
        end else if (rise) begin
          cntReg       <= CW'(1);
          repeatingReg <= 1'b0;
        end else if (rptFire) begin
          cntReg       <= CW'(1);
          repeatingReg <= 1'b1;
        end else begin
          cntReg       <= cntReg + CW'(1);
        end
      end

      assign evt = rise | rptFire;
    end else begin : gEdgeOnly
      assign evt = rise;
    end
  endgenerate

endmodule

// File: rtl/gol_cursor_ctrl.sv
// Edit-mode front end for the GOL display path. Conditions the raw buttons,
// owns the cursor, the viewport and run_mode, and issues cell-toggle write
// requests to the board memory.
//   clk, rst_b                 clock, synchronous active-low reset
//   btn_up/down/left/right     raw direction buttons (auto-repeat)
//   btn_zoom, btn_run, btn_tog raw buttons (edge only)
//   tog_ack                    board memory accepted the toggle request
//   run_mode                   1 = simulation running, 0 = edit
//   abs_cursR/C                cursor cell, absolute board coordinates
//   winR/C                     viewport top-left cell
//   win_numCells               viewport width in cells (32, 16 or 8)
//   tog_req, tog_addrR/C       toggle request held until tog_ack, with address
// K must be at least 5 so the widest (32-cell) viewport fits on the board.
module gol_cursor_ctrl
  import gol_cursor_ctrl_pkg::*;
#(
  parameter int K        = 6,
  parameter int HOLD_CYC = 5000000,
  parameter int RPT_CYC  = 1250000
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         btn_zoom,
  input  logic         btn_run,
  input  logic         btn_tog,
  input  logic         tog_ack,
  output logic         run_mode,
  output logic [K-1:0] abs_cursR,
  output logic [K-1:0] abs_cursC,
  output logic [K-1:0] winR,
  output logic [K-1:0] winC,
  output logic [7:0]   win_numCells,
  output logic         tog_req,
  output logic [K-1:0] tog_addrR,
  output logic [K-1:0] tog_addrC
);

  // ---------------------------------------------------------------- buttons
  logic [NUM_BTN-1:0] rawBtn;
  logic [NUM_BTN-1:0] btnEvt;

  assign rawBtn[BTN_UP]    = btn_up;
  assign rawBtn[BTN_DOWN]  = btn_down;
  assign rawBtn[BTN_LEFT]  = btn_left;
  assign rawBtn[BTN_RIGHT] = btn_right;
  assign rawBtn[BTN_ZOOM]  = btn_zoom;
  assign rawBtn[BTN_RUN]   = btn_run;
  assign rawBtn[BTN_TOG]   = btn_tog;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : gBtn
      gol_cursor_ctrl_btn_conditioner #(
        .HOLD_CYC  (HOLD_CYC),
        .RPT_CYC   (RPT_CYC),
        .REPEAT_EN (gi <= BTN_RIGHT)
      ) uCond (
        .clk   (clk),
        .rst_b (rst_b),
        .raw   (rawBtn[gi]),
        .evt   (btnEvt[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------- state
  logic         runModeReg;
  logic [K-1:0] cursRReg, cursCReg;
  logic [K-1:0] winRReg, winCReg;
  zoom_t        zoomReg;
  tog_state_t   togStateReg;
  logic         togReqReg;
  logic [K-1:0] togAddrRReg, togAddrCReg;

  logic [K-1:0] cursRNext, cursCNext;
  logic [K-1:0] winRNext, winCNext;
  zoom_t        zoomNext;
  logic [K:0]   nCur;
  logic [K:0]   nNew;
  logic         inReq;
  logic         editOk;
  action_t      act;

  // Keep the viewport around the cursor after a one-cell move.
  function automatic logic [K-1:0] followWin(input logic [K-1:0] curs,
                                             input logic [K-1:0] win,
                                             input logic [K:0]   n);
    logic [K:0] c;
    logic [K:0] w;
    c = {1'b0, curs};
    w = {1'b0, win};
    followWin = win;
    if (c < w) begin
      followWin = curs;
    end else if (c >= w + n) begin
      followWin = K'(c - n + (K+1)'(1));
    end
  endfunction

  // Centre the viewport on the cursor, clamped to the board. The low bound
  // can go negative, hence the signed K+1-bit arithmetic; the upper bound
  // 2^K - n is always non-negative and below 2^K.
  function automatic logic [K-1:0] zoomWin(input logic [K-1:0] curs,
                                           input logic [K:0]   n);
    logic [K:0]        span;
    logic signed [K:0] lo;
    logic signed [K:0] hi;
    span = (K+1)'(1) << K;
    hi   = $signed(span - n);
    lo   = $signed({1'b0, curs}) - $signed(n >> 1);
    if (lo[K]) begin
      zoomWin = '0;
    end else if (lo > hi) begin
      zoomWin = hi[K-1:0];
    end else begin
      zoomWin = lo[K-1:0];
    end
  endfunction

  assign nCur   = (K+1)'(zoomCells(zoomReg));
  assign inReq  = (togStateReg == REQ);
  assign editOk = !runModeReg && !inReq;

  // One action per cycle; events that lose, or are not allowed in the
  // current mode, are simply dropped.
  always_comb begin
    act = ACT_NONE;
    if (btnEvt[BTN_RUN]) begin
      act = ACT_RUN;
    end else if (btnEvt[BTN_TOG] && editOk) begin
      act = ACT_TOG;
    end else if (btnEvt[BTN_ZOOM] && !inReq) begin
      act = ACT_ZOOM;
    end else if (btnEvt[BTN_UP] && editOk) begin
      act = ACT_UP;
    end else if (btnEvt[BTN_DOWN] && editOk) begin
      act = ACT_DOWN;
    end else if (btnEvt[BTN_LEFT] && editOk) begin
      act = ACT_LEFT;
    end else if (btnEvt[BTN_RIGHT] && editOk) begin
      act = ACT_RIGHT;
    end
  end

  always_comb begin
    cursRNext = cursRReg;
    cursCNext = cursCReg;
    winRNext  = winRReg;
    winCNext  = winCReg;
    zoomNext  = zoomReg;
    nNew      = nCur;
    case (act)
      ACT_ZOOM: begin
        zoomNext = zoomStep(zoomReg);
        nNew     = (K+1)'(zoomCells(zoomNext));
        winRNext = zoomWin(cursRReg, nNew);
        winCNext = zoomWin(cursCReg, nNew);
      end
      ACT_UP: begin
        if (cursRReg != '0) cursRNext = cursRReg - K'(1);
        winRNext = followWin(cursRNext, winRReg, nCur);
      end
      ACT_DOWN: begin
        if (cursRReg != {K{1'b1}}) cursRNext = cursRReg + K'(1);
        winRNext = followWin(cursRNext, winRReg, nCur);
      end
      ACT_LEFT: begin
        if (cursCReg != '0) cursCNext = cursCReg - K'(1);
        winCNext = followWin(cursCNext, winCReg, nCur);
      end
      ACT_RIGHT: begin
        if (cursCReg != {K{1'b1}}) cursCNext = cursCReg + K'(1);
        winCNext = followWin(cursCNext, winCReg, nCur);
      end
      default: ;
    endcase
  end

  // Registered state, run-mode toggle and toggle-request FSM.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      runModeReg  <= 1'b0;
      cursRReg    <= '0;
      cursCReg    <= '0;
      winRReg     <= '0;
      winCReg     <= '0;
      zoomReg     <= Z32;
      togStateReg <= IDLE;
      togReqReg   <= 1'b0;
      togAddrRReg <= '0;
      togAddrCReg <= '0;
    end else begin
      cursRReg <= cursRNext;
      cursCReg <= cursCNext;
      winRReg  <= winRNext;
      winCReg  <= winCNext;
      zoomReg  <= zoomNext;
      if (act == ACT_RUN) runModeReg <= ~runModeReg;
      case (togStateReg)
        IDLE: begin
          if (act == ACT_TOG) begin
            togStateReg <= REQ;
            togReqReg   <= 1'b1;
            togAddrRReg <= cursRReg;
            togAddrCReg <= cursCReg;
          end
        end
        REQ: begin
          if (tog_ack) begin
            togStateReg <= IDLE;
            togReqReg   <= 1'b0;
          end
        end
        default: begin
          togStateReg <= IDLE;
          togReqReg   <= 1'b0;
        end
      endcase
    end
  end

  assign run_mode     = runModeReg;
  assign abs_cursR    = cursRReg;
  assign abs_cursC    = cursCReg;
  assign winR         = winRReg;
  assign winC         = winCReg;
  assign win_numCells = zoomCells(zoomReg);
  assign tog_req      = togReqReg;
  assign tog_addrR    = togAddrRReg;
  assign tog_addrC    = togAddrCReg;

endmodule

// File: tb/tb_gol_cursor_ctrl.sv
// Directed bench for gol_cursor_ctrl (K=6, HOLD_CYC=4, RPT_CYC=2). A small
// behavioural model is updated as stimulus is driven; each expected snapshot
// is queued and compared once the DUT has had its three-edge latency.
module tb_gol_cursor_ctrl;

  localparam int K    = 6;
  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3;
  localparam int B_ZOOM = 4, B_RUN = 5, B_TOG = 6;

  logic         clk = 1'b0;
  logic         rst_b;
  logic [6:0]   btn;
  logic         togAck;
  logic         run_mode;
  logic [K-1:0] abs_cursR, abs_cursC, winR, winC, tog_addrR, tog_addrC;
  logic [7:0]   win_numCells;
  logic         tog_req;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string tag;
    int    runMode;
    int    cursR;
    int    cursC;
    int    winR;
    int    winC;
    int    numCells;
    int    togReq;
    int    togR;
    int    togC;
  } snap_t;

  snap_t sbQ[$];

  // model state
  int mRun, mCursR, mCursC, mWinR, mWinC, mN, mTogReq, mTogR, mTogC;

  always #5 clk = ~clk;

  gol_cursor_ctrl #(.K(K), .HOLD_CYC(4), .RPT_CYC(2)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .btn_up       (btn[B_UP]),
    .btn_down     (btn[B_DOWN]),
    .btn_left     (btn[B_LEFT]),
    .btn_right    (btn[B_RIGHT]),
    .btn_zoom     (btn[B_ZOOM]),
    .btn_run      (btn[B_RUN]),
    .btn_tog      (btn[B_TOG]),
    .tog_ack      (togAck),
    .run_mode     (run_mode),
    .abs_cursR    (abs_cursR),
    .abs_cursC    (abs_cursC),
    .winR         (winR),
    .winC         (winC),
    .win_numCells (win_numCells),
    .tog_req      (tog_req),
    .tog_addrR    (tog_addrR),
    .tog_addrC    (tog_addrC)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------- model
  task automatic mReset();
    mRun = 0; mCursR = 0; mCursC = 0; mWinR = 0; mWinC = 0; mN = 32;
    mTogReq = 0; mTogR = 0; mTogC = 0;
  endtask

  function automatic int fw(input int c, input int w, input int n);
    if (c < w) return c;
    if (c >= w + n) return c - n + 1;
    return w;
  endfunction

  function automatic int zc(input int c, input int n);
    int v;
    v = c - n / 2;
    if (v < 0) v = 0;
    if (v > 64 - n) v = 64 - n;
    return v;
  endfunction

  task automatic mEvent(input int idx);
    bit edit;
    edit = (mRun == 0) && (mTogReq == 0);
    case (idx)
      B_RUN:  mRun = 1 - mRun;
      B_TOG:  if (edit) begin mTogReq = 1; mTogR = mCursR; mTogC = mCursC; end
      B_ZOOM: if (mTogReq == 0) begin
                mN    = (mN == 32) ? 16 : (mN == 16) ? 8 : 32;
                mWinR = zc(mCursR, mN);
                mWinC = zc(mCursC, mN);
              end
      B_UP:    if (edit) begin if (mCursR > 0)  mCursR--; mWinR = fw(mCursR, mWinR, mN); end
      B_DOWN:  if (edit) begin if (mCursR < 63) mCursR++; mWinR = fw(mCursR, mWinR, mN); end
      B_LEFT:  if (edit) begin if (mCursC > 0)  mCursC--; mWinC = fw(mCursC, mWinC, mN); end
      B_RIGHT: if (edit) begin if (mCursC < 63) mCursC++; mWinC = fw(mCursC, mWinC, mN); end
      default: ;
    endcase
  endtask

  // ------------------------------------------------------------- scoreboard
  task automatic expectNow(input string tag);
    snap_t s;
    s.tag = tag; s.runMode = mRun; s.cursR = mCursR; s.cursC = mCursC;
    s.winR = mWinR; s.winC = mWinC; s.numCells = mN; s.togReq = mTogReq;
    s.togR = mTogR; s.togC = mTogC;
    sbQ.push_back(s);
  endtask

  task automatic cmp(input string tag, input string field,
                     input logic [31:0] obs, input int expv);
    checks++;
    assert (obs === 32'(expv)) else begin
      failures++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, expv);
    end
  endtask

  task automatic checkOut();
    snap_t s;
    checks++;
    assert (sbQ.size() > 0) else begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0d expected=%0d", sbQ.size(), 1);
    end
    if (sbQ.size() > 0) begin
      s = sbQ.pop_front();
      cmp(s.tag, "run_mode", 32'(run_mode),     s.runMode);
      cmp(s.tag, "cursR",    32'(abs_cursR),    s.cursR);
      cmp(s.tag, "cursC",    32'(abs_cursC),    s.cursC);
      cmp(s.tag, "winR",     32'(winR),         s.winR);
      cmp(s.tag, "winC",     32'(winC),         s.winC);
      cmp(s.tag, "numCells", 32'(win_numCells), s.numCells);
      cmp(s.tag, "tog_req",  32'(tog_req),      s.togReq);
      cmp(s.tag, "tog_addrR", 32'(tog_addrR),   s.togR);
      cmp(s.tag, "tog_addrC", 32'(tog_addrC),   s.togC);
      $display("txn %-12s run=%0d curs=(%0d,%0d) win=(%0d,%0d) n=%0d req=%0d addr=(%0d,%0d)",
               s.tag, run_mode, abs_cursR, abs_cursC, winR, winC, win_numCells,
               tog_req, tog_addrR, tog_addrC);
    end
  endtask

  // One short press: high for one cycle, result visible after the third edge.
  task automatic press(input int idx, input string tag);
    btn[idx] = 1'b1;
    tick(1);
    btn[idx] = 1'b0;
    mEvent(idx);
    expectNow(tag);
    tick(2);
    checkOut();
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b  = 1'b0;
    btn    = '0;
    togAck = 1'b0;
    mReset();
    tick(3);

    // 1: reset, then idle
    rst_b = 1'b1;
    tick(20);
    expectNow("reset_idle");
    checkOut();

    // 2: walk right to C=31, step to 32 (window starts to follow), then hold
    for (int i = 0; i < 31; i++) press(B_RIGHT, "walk_right");
    press(B_RIGHT, "right_c32");
    btn[B_RIGHT] = 1'b1;
    tick(3);  mEvent(B_RIGHT); expectNow("hold_edge");  checkOut();
    tick(3);                   expectNow("hold_wait");  checkOut();
    tick(1);  mEvent(B_RIGHT); expectNow("hold_rpt1");  checkOut();
    tick(2);  mEvent(B_RIGHT); expectNow("hold_rpt2");  checkOut();
    tick(70);
    for (int i = 0; i < 40; i++) mEvent(B_RIGHT);
    expectNow("hold_sat");
    checkOut();
    btn[B_RIGHT] = 1'b0;
    tick(4);

    // 3: cursor to (40,40), zoom cycle, then zoom near the corner
    for (int i = 0; i < 40; i++) press(B_DOWN, "walk_down");
    for (int i = 0; i < 23; i++) press(B_LEFT, "walk_left");
    press(B_ZOOM, "zoom16");
    press(B_ZOOM, "zoom8");
    press(B_ZOOM, "zoom32");
    for (int i = 0; i < 38; i++) press(B_UP, "walk_up");
    for (int i = 0; i < 38; i++) press(B_LEFT, "walk_left");
    press(B_ZOOM, "zoom_corner");

    // 4: toggle request at (5,9), events dropped while pending, ack
    for (int i = 0; i < 3; i++) press(B_DOWN, "walk_down");
    for (int i = 0; i < 7; i++) press(B_RIGHT, "walk_right");
    press(B_TOG, "tog_req");
    press(B_DOWN, "down_in_req");
    tick(6);
    expectNow("req_held");
    checkOut();
    togAck = 1'b1;
    tick(1);
    togAck = 1'b0;
    mTogReq = 0;
    expectNow("tog_acked");
    checkOut();
    togAck = 1'b1;
    tick(2);
    togAck = 1'b0;
    expectNow("ack_idle");
    checkOut();

    // 5: run mode ignores tog/direction, zoom still applies
    press(B_RUN, "run_on");
    press(B_TOG, "tog_in_run");
    press(B_LEFT, "left_in_run");
    press(B_ZOOM, "zoom_in_run");

    // 6: run beats up in the same cycle; reset during a pending request
    btn[B_RUN] = 1'b1;
    btn[B_UP]  = 1'b1;
    tick(1);
    btn[B_RUN] = 1'b0;
    btn[B_UP]  = 1'b0;
    mEvent(B_RUN);
    expectNow("run_vs_up");
    tick(2);
    checkOut();
    tick(1);
    press(B_TOG, "tog_req2");
    rst_b = 1'b0;
    tick(1);
    mReset();
    expectNow("reset_in_req");
    checkOut();
    rst_b = 1'b1;
    tick(20);
    expectNow("post_reset");
    checkOut();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
